// File: rtl/hazard_tracker.sv
// Hazard controller for the 5-stage MIPS core.
// Tracks E/M/W destinations and derives the D-stage stall plus all forwarding selects.
module hazard_tracker #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned SEL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   rs_D,
  input  logic [RA_W-1:0]   rt_D,
  input  logic [1:0]        tuse_rs_D,
  input  logic [1:0]        tuse_rt_D,
  input  logic [RA_W-1:0]   a3_D,
  input  logic [1:0]        tnew_D,
  input  logic [1:0]        src_D,
  output logic              stall,
  output logic [SEL_W-1:0]  mfcmp1dSel,
  output logic [SEL_W-1:0]  mfcmp2dSel,
  output logic [SEL_W-1:0]  mfaluaSel,
  output logic [SEL_W-1:0]  mfalubSel,
  output logic [SEL_W-1:0]  mfdmwdSel
);

  localparam logic [1:0] SRC_DM  = 2'd1;
  localparam logic [1:0] SRC_PC4 = 2'd2;

  localparam logic [SEL_W-1:0] SEL_RF     = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_ALUC_M = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_PC4_M  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_ALUC_W = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_DMRD_W = SEL_W'(4);

  // Scoreboard entries for the E, M and W stages
  logic [RA_W-1:0] a3_e, rs_e, rt_e;
  logic [1:0]      tnew_e, src_e;
  logic [RA_W-1:0] a3_m, rt_m;
  logic [1:0]      tnew_m, src_m;
  logic [RA_W-1:0] a3_w;
  logic [1:0]      src_w;

  logic [1:0]      tnew_e_dec;

  // Register 0 is hard-wired, so it never matches a producer
  function automatic logic hit(input logic [RA_W-1:0] a3, input logic [RA_W-1:0] r);
    return (r != '0) && (a3 == r);
  endfunction

  function automatic logic need_stall(
    input logic [RA_W-1:0] r,
    input logic [1:0]      tuse,
    input logic [RA_W-1:0] a3e,
    input logic [1:0]      tne,
    input logic [RA_W-1:0] a3m,
    input logic [1:0]      tnm
  );
    return (hit(a3e, r) && (tuse < tne)) || (hit(a3m, r) && (tuse < tnm));
  endfunction

  // M wins over W; M only forwards once its result is ready
  function automatic logic [SEL_W-1:0] fwd_sel(
    input logic [RA_W-1:0] r,
    input logic [RA_W-1:0] a3m,
    input logic [1:0]      tnm,
    input logic [1:0]      srcm,
    input logic [RA_W-1:0] a3w,
    input logic [1:0]      srcw
  );
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (hit(a3m, r) && (tnm == 2'd0)) begin
      sel = (srcm == SRC_PC4) ? SEL_PC4_M : SEL_ALUC_M;
    end else if (hit(a3w, r)) begin
      sel = (srcw == SRC_DM) ? SEL_DMRD_W : SEL_ALUC_W;
    end
    return sel;
  endfunction

  function automatic logic [SEL_W-1:0] w_sel(
    input logic [RA_W-1:0] r,
    input logic [RA_W-1:0] a3w,
    input logic [1:0]      srcw
  );
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (hit(a3w, r)) begin
      sel = (srcw == SRC_DM) ? SEL_DMRD_W : SEL_ALUC_W;
    end
    return sel;
  endfunction

  assign tnew_e_dec = (tnew_e == 2'd0) ? 2'd0 : (tnew_e - 2'd1);

  // Stall and selects are combinational from scoreboard plus D-stage fields
  always_comb begin
    stall      = 1'b0;
    mfcmp1dSel = SEL_RF;
    mfcmp2dSel = SEL_RF;
    mfaluaSel  = SEL_RF;
    mfalubSel  = SEL_RF;
    mfdmwdSel  = SEL_RF;

    stall = need_stall(rs_D, tuse_rs_D, a3_e, tnew_e, a3_m, tnew_m)
          | need_stall(rt_D, tuse_rt_D, a3_e, tnew_e, a3_m, tnew_m);

    mfcmp1dSel = fwd_sel(rs_D, a3_m, tnew_m, src_m, a3_w, src_w);
    mfcmp2dSel = fwd_sel(rt_D, a3_m, tnew_m, src_m, a3_w, src_w);
    mfaluaSel  = fwd_sel(rs_e, a3_m, tnew_m, src_m, a3_w, src_w);
    mfalubSel  = fwd_sel(rt_e, a3_m, tnew_m, src_m, a3_w, src_w);
    mfdmwdSel  = w_sel(rt_m, a3_w, src_w);
  end

  // A stall inserts a bubble into E while M and W keep draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_e   <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
      tnew_e <= 2'd0;
      src_e  <= 2'd0;
      a3_m   <= '0;
      rt_m   <= '0;
      tnew_m <= 2'd0;
      src_m  <= 2'd0;
      a3_w   <= '0;
      src_w  <= 2'd0;
    end else begin
      if (stall) begin
        a3_e   <= '0;
        rs_e   <= '0;
        rt_e   <= '0;
        tnew_e <= 2'd0;
        src_e  <= 2'd0;
      end else begin
        a3_e   <= a3_D;
        rs_e   <= rs_D;
        rt_e   <= rt_D;
        tnew_e <= tnew_D;
        src_e  <= src_D;
      end
      a3_m   <= a3_e;
      rt_m   <= rt_e;
      tnew_m <= tnew_e_dec;
      src_m  <= src_e;
      a3_w   <= a3_m;
      src_w  <= src_m;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: instruction-level pipeline model plus directed literal checks
// and a randomized instruction stream.
module tb_hazard_tracker;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, src_D;
  logic       stall;
  logic [3:0] mfcmp1dSel, mfcmp2dSel, mfaluaSel, mfalubSel, mfdmwdSel;

  hazard_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .tuse_rs_D  (tuse_rs_D),
    .tuse_rt_D  (tuse_rt_D),
    .a3_D       (a3_D),
    .tnew_D     (tnew_D),
    .src_D      (src_D),
    .stall      (stall),
    .mfcmp1dSel (mfcmp1dSel),
    .mfcmp2dSel (mfcmp2dSel),
    .mfaluaSel  (mfaluaSel),
    .mfalubSel  (mfalubSel),
    .mfdmwdSel  (mfdmwdSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each instruction remembers its Tnew at E entry; its Tnew in a later stage is derived by age
  typedef struct {
    int a3;
    int tnew;
    int src;
    int rs;
    int rt;
  } ins_t;

  ins_t stg [3];  // 0 = E, 1 = M, 2 = W
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [7:0] act, input int expv);
    vectors++;
    if (act !== 8'(expv)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic int tnew_at(input int k);
    int t;
    t = stg[k].tnew - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int m_stall(input int r, input int tuse);
    if (r == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (stg[k].a3 == r && tuse < tnew_at(k)) return 1;
    return 0;
  endfunction

  function automatic int m_fwd(input int r);
    if (r == 0) return 0;
    if (stg[1].a3 == r && tnew_at(1) == 0) return (stg[1].src == 2) ? 2 : 1;
    if (stg[2].a3 == r) return (stg[2].src == 1) ? 4 : 3;
    return 0;
  endfunction

  function automatic int m_wsel(input int r);
    if (r != 0 && stg[2].a3 == r) return (stg[2].src == 1) ? 4 : 3;
    return 0;
  endfunction

  function automatic int m_dstall();
    return m_stall(int'(rs_D), int'(tuse_rs_D)) | m_stall(int'(rt_D), int'(tuse_rt_D));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) stg[k] = '{0, 0, 0, 0, 0};
  endtask

  task automatic model_advance();
    int st;
    if (!reset) begin
      model_clear();
    end else begin
      st = m_dstall();
      stg[2] = stg[1];
      stg[1] = stg[0];
      if (st != 0) stg[0] = '{0, 0, 0, 0, 0};
      else stg[0] = '{int'(a3_D), int'(tnew_D), int'(src_D), int'(rs_D), int'(rt_D)};
    end
  endtask

  task automatic compare_model();
    chk("stall",      {7'b0, stall},     m_dstall());
    chk("mfcmp1dSel", 8'(mfcmp1dSel),    m_fwd(int'(rs_D)));
    chk("mfcmp2dSel", 8'(mfcmp2dSel),    m_fwd(int'(rt_D)));
    chk("mfaluaSel",  8'(mfaluaSel),     m_fwd(stg[0].rs));
    chk("mfalubSel",  8'(mfalubSel),     m_fwd(stg[0].rt));
    chk("mfdmwdSel",  8'(mfdmwdSel),     m_wsel(stg[1].rt));
  endtask

  // Called at a falling edge; leaves time 1 unit later for sampling
  task automatic drive(input int rs, input int trs, input int rt, input int trt,
                       input int a3, input int tn, input int src);
    rs_D = 5'(rs); tuse_rs_D = 2'(trs);
    rt_D = 5'(rt); tuse_rt_D = 2'(trt);
    a3_D = 5'(a3); tnew_D = 2'(tn); src_D = 2'(src);
    #1;
  endtask

  task automatic idle();
    drive(0, 3, 0, 3, 0, 0, 0);
  endtask

  task automatic tick();
    compare_model();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  function automatic int rreg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 31 : v;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_stall"}, {7'b0, stall}, 0);
    chk({tag, "_cmp1"}, 8'(mfcmp1dSel), 0);
    chk({tag, "_cmp2"}, 8'(mfcmp2dSel), 0);
    chk({tag, "_alua"}, 8'(mfaluaSel), 0);
    chk({tag, "_alub"}, 8'(mfalubSel), 0);
    chk({tag, "_dmwd"}, 8'(mfdmwdSel), 0);
  endtask

  initial begin
    int kind, a3, tn, src;
    reset = 1'b0;
    model_clear();
    rs_D = '0; rt_D = '0; a3_D = '0;
    tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_D = '0; src_D = '0;
    @(negedge clk);

    // Reset: outputs zero whatever D presents
    drive(5, 0, 5, 0, 5, 2, 1);
    all_zero("reset");
    tick();
    reset = 1'b1;
    drive(5, 0, 0, 3, 0, 0, 0);
    tick();
    all_zero("post_reset");
    tick();

    // ALU result feeding a branch compare
    drive(0, 3, 0, 3, 8, 1, 0);
    tick();
    drive(8, 0, 0, 3, 0, 0, 0);
    chk("alu_br_stall", {7'b0, stall}, 1);
    tick();
    chk("alu_br_unstall", {7'b0, stall}, 0);
    chk("alu_br_cmp1", 8'(mfcmp1dSel), 1);
    tick();

    // Load-use on an ALU operand
    drive(0, 3, 0, 3, 9, 2, 1);
    tick();
    drive(0, 3, 9, 1, 0, 0, 0);
    chk("ld_use_stall", {7'b0, stall}, 1);
    tick();
    chk("ld_use_unstall", {7'b0, stall}, 0);
    tick();
    idle();
    chk("ld_use_alub", 8'(mfalubSel), 4);
    tick();

    // Link result forwarded to a compare
    drive(0, 3, 0, 3, 31, 0, 2);
    tick();
    drive(31, 0, 0, 3, 0, 0, 0);
    chk("link_e_stall", {7'b0, stall}, 0);
    chk("link_e_cmp1", 8'(mfcmp1dSel), 0);
    tick();
    chk("link_m_cmp1", 8'(mfcmp1dSel), 2);
    tick();
    chk("link_w_cmp1", 8'(mfcmp1dSel), 3);
    tick();

    // M and W both write $4: M wins
    drive(0, 3, 0, 3, 4, 1, 0);
    tick();
    drive(0, 3, 0, 3, 4, 1, 0);
    tick();
    idle();
    tick();
    drive(4, 3, 0, 3, 0, 0, 0);
    chk("prio_cmp1", 8'(mfcmp1dSel), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    all_zero("reg0");
    tick();

    // Store data from a load in W
    drive(0, 3, 0, 3, 10, 2, 1);
    tick();
    drive(0, 3, 10, 2, 0, 0, 0);
    chk("st_e_stall", {7'b0, stall}, 0);
    tick();
    idle();
    tick();
    chk("st_dmwd", 8'(mfdmwdSel), 4);
    tick();

    // Reset asserted during a live stall
    drive(0, 3, 0, 3, 8, 1, 0);
    tick();
    drive(8, 0, 0, 3, 0, 0, 0);
    chk("rst_pre_stall", {7'b0, stall}, 1);
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("rst_async_stall", {7'b0, stall}, 0);
    compare_model();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    reset = 1'b1;
    idle();
    tick();

    // Randomized instruction stream with occasional asynchronous reset
    repeat (3000) begin
      kind = $urandom_range(0, 4);
      a3 = rreg();
      case (kind)
        0: begin tn = 1; src = 0; end
        1: begin tn = 2; src = 1; end
        2: begin tn = 0; src = 2; end
        3: begin tn = 0; src = 0; a3 = 0; end
        default: begin tn = $urandom_range(0, 3); src = $urandom_range(0, 2); end
      endcase
      drive(rreg(), $urandom_range(0, 3), rreg(), $urandom_range(0, 3), a3, tn, src);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        #1;
        model_clear();
        compare_model();
        @(posedge clk);
        model_advance();
        @(negedge clk);
        reset = 1'b1;
        #1;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Keeps a register-destination scoreboard for the E, M and W stages. Each entry holds the destination register, remaining Tnew and result source.
- From that scoreboard it produces the D-stage stall and every forwarding-mux select: D-stage compare operands, E-stage ALU operands and M-stage store data.
- It sits directly upstream of the D-stage compare-operand forwarding muxes and drives their 4-bit select inputs.

Parameters:
- RA_W, 5, register address width
- SEL_W, 4, forwarding select width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rs_D  in  RA_W  D-stage source register 1
- rt_D  in  RA_W  D-stage source register 2
- tuse_rs_D  in  2  cycles until rs is consumed (0=D compare, 1=E ALU, 2=M store, 3=not read)
- tuse_rt_D  in  2  same encoding, for rt
- a3_D  in  RA_W  destination register of D instruction (0 = no write)
- tnew_D  in  2  Tnew on entry to E (ALU=1, DM load=2, link=0)
- src_D  in  2  result source (0=ALU, 1=DM, 2=PC4 link)
- stall  out  1  freeze PC and F/D register, bubble into E
- mfcmp1dSel  out  SEL_W  D compare operand 1 select
- mfcmp2dSel  out  SEL_W  D compare operand 2 select
- mfaluaSel  out  SEL_W  E ALU operand A select
- mfalubSel  out  SEL_W  E ALU operand B select
- mfdmwdSel  out  SEL_W  M store-data select

Behaviour:
- Select encoding, common to all selects:
  - 0 = register-file / pipelined value
  - 1 = ALUC_M
  - 2 = pc4_M
  - 3 = ALUC_W
  - 4 = DMRD_W
  - 5..15 are never driven.
- State:
  - E entry: a3, tnew, src, rs, rt.
  - M entry: a3, tnew, src, rt.
  - W entry: a3, src.
- Reset (reset=0, asynchronous): all entries cleared (a3=0, tnew=0, src=0, rs=rt=0). With cleared state, all outputs are 0 for any D inputs.
- Clock edge, no stall:
  - E <= D fields.
  - M <= E with tnew = max(tnew_E-1, 0).
  - W <= M.
- Clock edge, stall=1: E <= bubble (all zero); M <= E and W <= M advance as normal.
- Match rule: a stage matches register r iff a3_stage == r and r != 0.
- Stall (combinational): asserted when, for rs_D or rt_D, either condition holds:
  - E matches with tuse < tnew_E, or
  - M matches with tuse < tnew_M.
  - W never causes a stall.
- D compare selects (rs_D → mfcmp1dSel, rt_D → mfcmp2dSel), priority M over W:
  - M matches and tnew_M==0: 2 if src_M==PC4, else 1.
  - Else W matches: 4 if src_W==DM, else 3. The W link value travels in ALUC_W.
  - Else 0.
  - E is never a forward source for D. An E match with tnew_E==0 (link) yields stall only if tuse < 0, which cannot happen. So a link in E selects 0 and the value is obtained one cycle later from M.
  - Any case where forwarding would be incorrect is covered by stall.
- E ALU selects: same rule using rs_E / rt_E against the M and W entries.
- M store select (mfdmwdSel): rt_M against W only → 4 (DM) or 3 (other), else 0.
- Boundary cases:
  - Register 0 never forwards and never stalls.
  - Matches in both M and W: M wins.
  - tnew saturates at 0 and never wraps.
  - tuse=3 never stalls.
  - Reset asserted mid-stall: state clears immediately and stall drops the same cycle.
- Latency: selects and stall are combinational from current state and D inputs. The scoreboard update takes 1 cycle.

Test Plan:
- Reset check: reset=0 with rs_D=5, a3 inputs arbitrary → stall=0 and all selects 0. Release reset, then one idle cycle → still 0.
- ALU-to-branch stall: cycle0 D: a3_D=8, tnew_D=1, src_D=0. Cycle1 D: rs_D=8, tuse_rs_D=0 → stall=1 for one cycle. Next cycle mfcmp1dSel=1, stall=0.
- Load-use stall: load a3_D=9, tnew_D=2, src_D=1. Next instruction rt_D=9, tuse_rt_D=1 → stall=1 for 1 cycle. Then mfalubSel=4 once the instruction is in E, with the load in W.
- Link forward: jal a3_D=31, tnew_D=0, src_D=2. Following beq rs_D=31, tuse=0 → stall=0. One cycle later (jal in M) mfcmp1dSel=2. When jal is in W → mfcmp1dSel=3.
- Priority and $0:
  - M and W both hold a3=4 (ALU results) → mfcmp1dSel=1.
  - a3=0 everywhere with rs_D=0 → all selects 0, stall=0.
- Store data: lw a3=10 in W, sw rt=10 in M → mfdmwdSel=4. Assert reset during an active stall → stall=0 asynchronously.
